// File: rtl/segre_dcache_arbiter.sv
// rtl/segre_dcache_arbiter.sv - MEM-stage data-cache port arbiter (mmu refill / load / store-buffer drain)
package segre_dcache_pkg;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} memop_data_type_e;
endpackage

module segre_dcache_arbiter
  import segre_dcache_pkg::*;
#(
  parameter int WORD_SIZE        = 32,
  parameter int ADDR_SIZE        = 32,
  parameter int DCACHE_LANE_SIZE = 128,
  parameter int STARVE_MAX       = 8,
  parameter int DRAIN_BURST      = 4
) (
  input  logic                        clk_i,
  input  logic                        rsn_i,
  input  logic                        mmu_req_i,
  input  logic [ADDR_SIZE-1:0]        mmu_addr_i,
  input  logic [DCACHE_LANE_SIZE-1:0] mmu_data_i,
  output logic                        mmu_gnt_o,
  input  logic                        ld_req_i,
  input  logic [WORD_SIZE-1:0]        ld_addr_i,
  input  memop_data_type_e            ld_type_i,
  output logic                        ld_gnt_o,
  output logic                        ld_stall_o,
  input  logic                        sb_req_i,
  input  logic                        sb_full_i,
  input  logic [ADDR_SIZE-1:0]        sb_addr_i,
  input  logic [WORD_SIZE-1:0]        sb_data_i,
  input  memop_data_type_e            sb_type_i,
  output logic                        sb_gnt_o,
  output logic                        dc_rd_o,
  output logic                        dc_wr_o,
  output logic                        dc_mmu_wr_o,
  output logic [ADDR_SIZE-1:0]        dc_addr_o,
  output logic [WORD_SIZE-1:0]        dc_data_o,
  output logic [DCACHE_LANE_SIZE-1:0] dc_mmu_data_o,
  output memop_data_type_e            dc_type_o,
  output logic                        drain_mode_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(DRAIN_BURST + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
  localparam logic [SW-1:0] STARVE_TOP  = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BURST_LAST  = BW'(DRAIN_BURST - 1);
  localparam logic [BW-1:0] BURST_TOP   = BW'(DRAIN_BURST);

  typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} state_e;

  state_e        state, state_next;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          sb_denied;

  assign sb_denied = sb_req_i & ~sb_gnt_o;

  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) state <= NORMAL;
    else       state <= state_next;
  end

  // Missing sb_req_i overrides sb_full_i: no entry, and an immediate exit.
  always_comb begin
    state_next = state;
    case (state)
      NORMAL:
        if (sb_req_i && (sb_full_i || (sb_denied && starve_cnt >= STARVE_LAST)))
          state_next = DRAIN;
      DRAIN:
        if (!sb_req_i)
          state_next = NORMAL;
        else if (sb_gnt_o && burst_cnt >= BURST_LAST && !sb_full_i)
          state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  always_comb begin
    mmu_gnt_o = 1'b0;
    ld_gnt_o  = 1'b0;
    sb_gnt_o  = 1'b0;
    if (!rsn_i) begin
      if (mmu_req_i)             mmu_gnt_o = 1'b1;
      else if (state == DRAIN) begin
        if (sb_req_i)            sb_gnt_o  = 1'b1;
        else if (ld_req_i)       ld_gnt_o  = 1'b1;
      end else begin
        if (ld_req_i)            ld_gnt_o  = 1'b1;
        else if (sb_req_i)       sb_gnt_o  = 1'b1;
      end
    end
  end

  assign ld_stall_o    = ~rsn_i & ld_req_i & ~ld_gnt_o;
  assign dc_mmu_wr_o   = mmu_gnt_o;
  assign dc_rd_o       = ld_gnt_o;
  assign dc_wr_o       = sb_gnt_o;
  assign dc_addr_o     = mmu_gnt_o ? mmu_addr_i : (sb_gnt_o ? sb_addr_i : ADDR_SIZE'(ld_addr_i));
  assign dc_type_o     = sb_gnt_o ? sb_type_i : ld_type_i;
  assign dc_data_o     = sb_data_i;
  assign dc_mmu_data_o = mmu_data_i;
  assign drain_mode_o  = (state == DRAIN);

  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i)
      starve_cnt <= '0;
    else if ((state == NORMAL && state_next == DRAIN) || !sb_denied)
      starve_cnt <= '0;
    else if (starve_cnt < STARVE_TOP)
      starve_cnt <= starve_cnt + SW'(1);
  end

  // Only counts while staying in DRAIN, so it is zero on every entry and after every exit.
  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i)
      burst_cnt <= '0;
    else if (state != DRAIN || state_next != DRAIN)
      burst_cnt <= '0;
    else if (sb_gnt_o && burst_cnt < BURST_TOP)
      burst_cnt <= burst_cnt + BW'(1);
  end

endmodule

// File: tb/tb_segre_dcache_arbiter.sv
// tb/tb_segre_dcache_arbiter.sv - directed self-checking bench for segre_dcache_arbiter
module tb_segre_dcache_arbiter;
  import segre_dcache_pkg::*;

  logic clk = 1'b0;
  logic rsn = 1'b1;
  logic mmu_req = 0, ld_req = 0, sb_req = 0, sb_full = 0;
  logic [31:0]  mmu_addr = 32'h0000_1000, ld_addr = 32'h0000_2004, sb_addr = 32'h0000_3008;
  logic [127:0] mmu_data = 128'hA5A5_0001_0002_0003_0004_0005_0006_0007;
  logic [31:0]  sb_data  = 32'hDEAD_BEEF;
  memop_data_type_e ld_type = HALF, sb_type = BYTE;
  logic mmu_gnt, ld_gnt, ld_stall, sb_gnt, dc_rd, dc_wr, dc_mmu_wr, drain_mode;
  logic [31:0] dc_addr, dc_data;
  logic [127:0] dc_mmu_data;
  memop_data_type_e dc_type;

  int checks = 0;
  int errors = 0;

  segre_dcache_arbiter dut (
    .clk_i(clk), .rsn_i(rsn),
    .mmu_req_i(mmu_req), .mmu_addr_i(mmu_addr), .mmu_data_i(mmu_data), .mmu_gnt_o(mmu_gnt),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_type_i(ld_type), .ld_gnt_o(ld_gnt), .ld_stall_o(ld_stall),
    .sb_req_i(sb_req), .sb_full_i(sb_full), .sb_addr_i(sb_addr), .sb_data_i(sb_data), .sb_type_i(sb_type),
    .sb_gnt_o(sb_gnt), .dc_rd_o(dc_rd), .dc_wr_o(dc_wr), .dc_mmu_wr_o(dc_mmu_wr),
    .dc_addr_o(dc_addr), .dc_data_o(dc_data), .dc_mmu_data_o(dc_mmu_data), .dc_type_o(dc_type),
    .drain_mode_o(drain_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // grants as {mmu, ld, sb}, strobes as {mmu_wr, rd, wr}
  task automatic chk_grants(input string tag, input logic [2:0] g, input logic stall, input logic drain);
    chk({tag, ".gnt"}, {mmu_gnt, ld_gnt, sb_gnt}, g);
    chk({tag, ".strobe"}, {dc_mmu_wr, dc_rd, dc_wr}, g);
    chk({tag, ".stall"}, ld_stall, stall);
    chk({tag, ".drain"}, drain_mode, drain);
  endtask

  initial begin
    @(negedge clk);
    chk_grants("reset_idle", 3'b000, 1'b0, 1'b0);
    mmu_req = 1; ld_req = 1; sb_req = 1;
    #1;
    chk_grants("reset_all_req", 3'b000, 1'b0, 1'b0);

    // all three requesters in NORMAL: mmu wins
    next_cycle();
    rsn = 0;
    @(negedge clk);
    chk_grants("normal_all", 3'b100, 1'b1, 1'b0);
    chk("normal_all.addr", dc_addr, 32'h0000_1000);
    chk("normal_all.mmu_data", dc_mmu_data, 128'hA5A5_0001_0002_0003_0004_0005_0006_0007);
    chk("normal_all.sb_data", dc_data, 32'hDEAD_BEEF);

    next_cycle();
    mmu_req = 0; sb_req = 0;
    @(negedge clk);
    chk_grants("ld_only", 3'b010, 1'b0, 1'b0);
    chk("ld_only.addr", dc_addr, 32'h0000_2004);
    chk("ld_only.type", dc_type, HALF);

    next_cycle();
    ld_req = 0; sb_req = 1;
    @(negedge clk);
    chk_grants("sb_only", 3'b001, 1'b0, 1'b0);
    chk("sb_only.addr", dc_addr, 32'h0000_3008);
    chk("sb_only.type", dc_type, BYTE);

    // starvation: ld and sb held; ld wins 8 cycles, then 4-cycle drain burst
    next_cycle();
    ld_req = 1; sb_req = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_grants($sformatf("starve_ld%0d", i), 3'b010, 1'b0, 1'b0);
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_grants($sformatf("starve_drain%0d", i), 3'b001, 1'b1, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    chk_grants("starve_back", 3'b010, 1'b0, 1'b0);
    chk("starve_back.starve_cnt", dut.starve_cnt, 0);
    next_cycle();
    sb_req = 0;
    next_cycle();

    // sb_full pulse
    sb_req = 1; sb_full = 1;
    @(negedge clk);
    chk_grants("full_pulse", 3'b010, 1'b0, 1'b0);
    next_cycle();
    sb_full = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_grants($sformatf("full_drain%0d", i), 3'b001, 1'b1, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    chk_grants("full_back", 3'b010, 1'b0, 1'b0);
    next_cycle();
    sb_req = 0;
    next_cycle();

    // sb_req drops after 2 drain grants
    sb_req = 1; sb_full = 1;
    next_cycle();
    sb_full = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_grants($sformatf("drop_drain%0d", i), 3'b001, 1'b1, 1'b1);
      next_cycle();
    end
    sb_req = 0;
    @(negedge clk);
    chk_grants("drop_last", 3'b010, 1'b0, 1'b1);
    next_cycle();
    @(negedge clk);
    chk_grants("drop_exit", 3'b010, 1'b0, 1'b0);
    chk("drop_exit.burst_cnt", dut.burst_cnt, 0);
    chk("drop_exit.starve_cnt", dut.starve_cnt, 0);
    next_cycle();

    // mmu interrupts a drain burst for 2 cycles
    sb_req = 1; sb_full = 1;
    next_cycle();
    sb_full = 0;
    @(negedge clk);
    chk_grants("mmu_mid_sb0", 3'b001, 1'b1, 1'b1);
    next_cycle();
    mmu_req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_grants($sformatf("mmu_mid_mmu%0d", i), 3'b100, 1'b1, 1'b1);
      chk($sformatf("mmu_mid_mmu%0d.burst_cnt", i), dut.burst_cnt, 1);
      next_cycle();
    end
    mmu_req = 0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk_grants($sformatf("mmu_mid_sb%0d", i), 3'b001, 1'b1, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    chk_grants("mmu_mid_exit", 3'b010, 1'b0, 1'b0);
    next_cycle();
    sb_req = 0;
    next_cycle();

    // reset asserted mid-drain with everything requesting
    sb_req = 1; sb_full = 1;
    next_cycle();
    sb_full = 0;
    @(negedge clk);
    chk_grants("rst_pre", 3'b001, 1'b1, 1'b1);
    next_cycle();
    mmu_req = 1;
    rsn = 1;
    #1;
    chk_grants("rst_mid", 3'b000, 1'b0, 1'b0);
    next_cycle();
    mmu_req = 0;
    rsn = 0;
    @(negedge clk);
    chk_grants("rst_after", 3'b010, 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("rst_after.starve_cnt", dut.starve_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/segre_dcache_arbiter.md
# segre_dcache_arbiter

Single-port scheduler for the data-cache data array in the MEM stage. Three requesters compete for the port: MMU line refills, pipeline loads and store-buffer drains. The block picks one winner per cycle, drives the cache port controls and returns grants and stall to the requesters. A starvation counter and a drain-mode FSM keep stores from being locked out by a steady stream of loads.

## Interface
Parameters:
- WORD_SIZE, 32, data word width
- ADDR_SIZE, 32, address width
- DCACHE_LANE_SIZE, 128, refill line width
- STARVE_MAX, 8, consecutive denied store-buffer cycles that force drain mode (≥2)
- DRAIN_BURST, 4, minimum store-buffer grants per drain episode (≥1)

Ports (clock/reset: one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- rsn_i  in  1  asynchronous, active-high reset
- mmu_req_i  in  1  refill line ready
- mmu_addr_i  in  ADDR_SIZE  refill line address
- mmu_data_i  in  DCACHE_LANE_SIZE  refill line
- mmu_gnt_o  out  1  refill accepted this cycle
- ld_req_i  in  1  load in MEM stage
- ld_addr_i  in  WORD_SIZE  load address
- ld_type_i  in  memop_data_type_e  load size
- ld_gnt_o  out  1  load reads the cache this cycle
- ld_stall_o  out  1  load present but not granted
- sb_req_i  in  1  store buffer has a valid head entry
- sb_full_i  in  1  store buffer full
- sb_addr_i  in  ADDR_SIZE  head entry address
- sb_data_i  in  WORD_SIZE  head entry data
- sb_type_i  in  memop_data_type_e  head entry size
- sb_gnt_o  out  1  head entry written; store buffer pops it
- dc_rd_o, dc_wr_o, dc_mmu_wr_o  out  1 each  cache port strobes
- dc_addr_o  out  ADDR_SIZE  cache address
- dc_data_o  out  WORD_SIZE  store data
- dc_mmu_data_o  out  DCACHE_LANE_SIZE  refill data
- dc_type_o  out  memop_data_type_e  access size
- drain_mode_o  out  1  FSM is in DRAIN

## Operation
- Grants are one-hot or zero. At most one strobe among dc_rd_o, dc_wr_o and dc_mmu_wr_o is high.
- Priority in NORMAL: mmu > ld > sb.
- Priority in DRAIN: mmu > sb > ld.
- Grants apply only to requests asserted in the same cycle.
- Strobe mapping: dc_mmu_wr_o = mmu_gnt_o, dc_rd_o = ld_gnt_o, dc_wr_o = sb_gnt_o.
- dc_addr_o: mmu_addr_i if mmu granted; else sb_addr_i if sb granted; else ld_addr_i.
- dc_type_o: sb_type_i if sb granted; else ld_type_i.
- dc_data_o = sb_data_i and dc_mmu_data_o = mmu_data_i, unconditionally.
- ld_stall_o = ld_req_i & ~ld_gnt_o.
- starve_cnt (registered, saturating at STARVE_MAX):
  - increments when sb_req_i & ~sb_gnt_o;
  - clears on sb_gnt_o or ~sb_req_i.
- FSM states and transitions:
  - NORMAL → DRAIN when sb_full_i is high, or when starve_cnt == STARVE_MAX-1 and sb is denied this cycle.
  - DRAIN:
    - burst_cnt clears on entry and increments on each sb_gnt_o, saturating at DRAIN_BURST.
    - DRAIN → NORMAL when ~sb_req_i.
    - DRAIN → NORMAL when the cycle's sb grant brings burst_cnt to DRAIN_BURST and sb_full_i is low.
    - If sb_full_i is still high at that point, stay in DRAIN.
  - Entering DRAIN clears starve_cnt.
- Simultaneous events:
  - mmu_req_i in DRAIN still wins. That cycle denies sb and does not advance burst_cnt.
  - sb_full_i and ~sb_req_i cannot coexist. If they do, ~sb_req_i wins (exit / no entry).
- Reset (asynchronous, any time): FSM goes to NORMAL and both counters to 0. While rsn_i is high, every grant, strobe and ld_stall_o is forced to 0. An in-flight refill is dropped; the MMU holds mmu_req_i until granted.

## Timing
- Arbitration is combinational, with 0-cycle latency from request to grant/strobe. The cache samples the strobes at the next clk_i edge.
- FSM and counters update on the clk_i rising edge. drain_mode_o is registered, so mode changes take effect the cycle after the triggering condition.
- Reset values: drain_mode_o = 0, starve_cnt = 0, burst_cnt = 0, all grants and strobes = 0.
- Requesters hold req and payload stable until granted. A grant consumes exactly one access.

## Test plan
- mmu_req_i, ld_req_i and sb_req_i all high in NORMAL → mmu_gnt_o = 1, dc_mmu_wr_o = 1, ld_stall_o = 1, sb_gnt_o = 0, dc_addr_o = mmu_addr_i.
- ld_req_i and sb_req_i held high, STARVE_MAX = 8, no mmu:
  - ld granted for cycles 0–7;
  - drain_mode_o = 1 from cycle 8;
  - sb_gnt_o = 1 for 4 cycles with ld_stall_o = 1;
  - then back to NORMAL, and ld is granted again.
- sb_full_i pulsed one cycle with ld traffic → DRAIN next cycle. After 4 sb grants with sb_full_i = 0 → NORMAL.
- In DRAIN, sb_req_i drops after 2 grants → drain_mode_o = 0 next cycle, burst_cnt = 0, starve_cnt = 0.
- In DRAIN, mmu_req_i for 2 cycles mid-burst → mmu granted twice, burst_cnt frozen, 4 sb grants total before exit.
- Assert rsn_i mid-DRAIN with all requests high → all grants and strobes 0 immediately. After release: NORMAL, ld granted first cycle, starve_cnt restarts from 0.
